// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM dead-time path.
// Field widths here are also used by the register file.
package pwm_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_LO_ON  = 3'd1,
    ST_DEAD_R = 3'd2,
    ST_HI_ON  = 3'd3,
    ST_DEAD_F = 3'd4
  } pwm_st_e;

endpackage

// File: rtl/pwm_dt_cnt.sv
// Loadable dead-time down-counter with zero flag.
// Clear wins over load, load wins over decrement.
module pwm_dt_cnt
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [DT_W-1:0] i_val,
  input  logic            i_dec,
  output logic            o_zero
);

  logic [DT_W-1:0] r_cnt;

  assign o_zero = (r_cnt == '0);

  // count register: clear / load / saturating decrement
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && !o_zero) begin
      r_cnt <= r_cnt - DT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate drive with per-edge dead time.
// Optional fault latch when DT_FAULT_EN is defined.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dt_en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_rise,
  input  logic [DT_W-1:0] dt_fall,
`ifdef DT_FAULT_EN
  input  logic            fault,
  input  logic            flt_clr,
  output logic            flt_lat,
`endif
  output logic            gate_hi,
  output logic            gate_lo,
  output logic            dead
);

  logic    r_pwm_q;
  pwm_st_e r_state;
  pwm_st_e w_next;
  logic    w_load;
  logic    w_dec;
  logic    w_zero;
  logic    w_force_off;
  logic    w_flt_block;
  logic    w_hi;
  logic    w_lo;
  logic    w_dead;
  logic    r_hi;
  logic    r_lo;
  logic    r_dead;
  logic [DT_W-1:0] w_ld_val;

`ifdef DT_FAULT_EN
  logic r_flt_s1;
  logic r_flt_s2;
  logic r_flt_lat;

  // fault synchroniser and sticky latch; a live fault beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flt_s1  <= 1'b0;
      r_flt_s2  <= 1'b0;
      r_flt_lat <= 1'b0;
    end else begin
      r_flt_s1 <= fault;
      r_flt_s2 <= r_flt_s1;
      if (r_flt_s2) begin
        r_flt_lat <= 1'b1;
      end else if (flt_clr && !fault
                   && !r_flt_s1) begin
        r_flt_lat <= 1'b0;
      end
    end
  end

  assign w_flt_block = r_flt_s2 | r_flt_lat;
  assign flt_lat     = r_flt_lat;
`else
  assign w_flt_block = 1'b0;
`endif

  assign w_force_off = !dt_en || w_flt_block;

  // input register and state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_q <= 1'b0;
      r_state <= ST_OFF;
    end else begin
      r_pwm_q <= pwm_in;
      r_state <= w_next;
    end
  end

  // next state; a zero dead time swaps sides directly
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_ld_val = '0;
    if (w_force_off) begin
      w_next = ST_OFF;
    end else begin
      unique case (r_state)
        ST_OFF, ST_LO_ON: begin
          if (!r_pwm_q) begin
            w_next = ST_LO_ON;
          end else if (dt_rise == '0) begin
            w_next = ST_HI_ON;
          end else begin
            w_next   = ST_DEAD_R;
            w_load   = 1'b1;
            w_ld_val = dt_rise - DT_W'(1);
          end
        end
        ST_DEAD_R: begin
          if (!r_pwm_q) begin
            w_next = ST_LO_ON;
          end else if (w_zero) begin
            w_next = ST_HI_ON;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_HI_ON: begin
          if (r_pwm_q) begin
            w_next = ST_HI_ON;
          end else if (dt_fall == '0) begin
            w_next = ST_LO_ON;
          end else begin
            w_next   = ST_DEAD_F;
            w_load   = 1'b1;
            w_ld_val = dt_fall - DT_W'(1);
          end
        end
        ST_DEAD_F: begin
          if (r_pwm_q) begin
            w_next = ST_HI_ON;
          end else if (w_zero) begin
            w_next = ST_LO_ON;
          end else begin
            w_dec = 1'b1;
          end
        end
        default: w_next = ST_OFF;
      endcase
    end
  end

  pwm_dt_cnt #(
    .DT_W (DT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_force_off),
    .i_load (w_load),
    .i_val  (w_ld_val),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  // output decode from the state being entered
  always_comb begin
    w_hi   = (w_next == ST_HI_ON);
    w_lo   = (w_next == ST_LO_ON);
    w_dead = (w_next == ST_DEAD_R)
          || (w_next == ST_DEAD_F);
  end

  // registered gate drives, aligned with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= 1'b0;
      r_lo   <= 1'b0;
      r_dead <= 1'b0;
    end else begin
      r_hi   <= w_hi;
      r_lo   <= w_lo;
      r_dead <= w_dead;
    end
  end

  assign gate_hi = r_hi;
  assign gate_lo = r_lo;
  assign dead    = r_dead;

  a_no_overlap: assert property (
    @(posedge clk) !(r_hi && r_lo)
  );

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime.
// Define DT_FAULT_EN to also exercise the fault latch.
module tb_pwm_deadtime;
  import pwm_pkg::*;

  localparam int W = DT_W_DEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst     = 1'b1;
  logic         dt_en   = 1'b0;
  logic         pwm_in  = 1'b0;
  logic [W-1:0] dt_rise = '0;
  logic [W-1:0] dt_fall = '0;
  logic         gate_hi;
  logic         gate_lo;
  logic         dead;
  logic         flt_v;
`ifdef DT_FAULT_EN
  logic         fault   = 1'b0;
  logic         flt_clr = 1'b0;
  logic         flt_lat;
  assign flt_v = flt_lat;
`else
  assign flt_v = 1'b0;
`endif

  pwm_deadtime #(
    .DT_W (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dt_en   (dt_en),
    .pwm_in  (pwm_in),
    .dt_rise (dt_rise),
    .dt_fall (dt_fall),
`ifdef DT_FAULT_EN
    .fault   (fault),
    .flt_clr (flt_clr),
    .flt_lat (flt_lat),
`endif
    .gate_hi (gate_hi),
    .gate_lo (gate_lo),
    .dead    (dead)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [3:0] sb[$];

  // reference: side = -1 off, 0 low, 1 high; k = cycles the
  // delayed pwm has disagreed with side; d = dead time latched
  // when the disagreement began
  int   m_side = -1;
  int   m_k    = 0;
  int   m_d    = 0;
  logic m_pq   = 1'b0;
  logic m_fs1  = 1'b0;
  logic m_fs2  = 1'b0;
  logic m_lat  = 1'b0;

  task automatic step();
    logic       p;
    logic       blk;
    logic [3:0] e;
    @(posedge clk);
    p   = m_pq;
    blk = 1'b0;
    if (rst) begin
      m_side = -1;
      m_k    = 0;
      m_pq   = 1'b0;
      m_fs1  = 1'b0;
      m_fs2  = 1'b0;
      m_lat  = 1'b0;
    end else begin
`ifdef DT_FAULT_EN
      blk = m_fs2 | m_lat;
      if (m_fs2) m_lat = 1'b1;
      else if (flt_clr && !fault && !m_fs1) m_lat = 1'b0;
      m_fs2 = m_fs1;
      m_fs1 = fault;
`endif
      if (!dt_en || blk) begin
        m_side = -1;
        m_k    = 0;
      end else begin
        if (m_side < 0) begin
          m_side = 0;
          m_k    = 0;
        end
        if (int'(p) == m_side) begin
          m_k = 0;
        end else begin
          if (m_k == 0) m_d = p ? int'(dt_rise) : int'(dt_fall);
          m_k++;
          if (m_k > m_d) begin
            m_side = int'(p);
            m_k    = 0;
          end
        end
      end
      m_pq = pwm_in;
    end
    e = {m_side == 1 && m_k == 0,
         m_side == 0 && m_k == 0,
         m_side >= 0 && m_k > 0,
         m_lat};
    sb.push_back(e);
    #1;
  endtask

  task automatic run(input int n, input logic p);
    pwm_in = p;
    repeat (n) step();
  endtask

  // monitor: one expected word per clock
  always @(negedge clk) begin
    logic [3:0] e;
    logic [3:0] a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {gate_hi, gate_lo, dead, flt_v};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL gates cyc=%0d hi,lo,dead,flt got %b want %b",
                 cyc, a, e);
      end
      checks++;
      if (gate_hi && gate_lo) begin
        errors++;
        $display("FAIL overlap cyc=%0d hi=%b lo=%b want not both",
                 cyc, gate_hi, gate_lo);
      end
    end
    cyc++;
  end

  initial begin
    rst = 1'b1;
    repeat (2) step();
    rst   = 1'b0;
    dt_en = 1'b1;
    // square 20/20 with 3/5 dead
    dt_rise = 8'd3;
    dt_fall = 8'd5;
    for (int i = 0; i < 3; i++) begin
      run(20, 1'b0);
      run(20, 1'b1);
    end
    // zero dead time
    dt_rise = 8'd0;
    dt_fall = 8'd0;
    for (int i = 0; i < 4; i++) begin
      run(7, 1'b0);
      run(7, 1'b1);
    end
    run(1, 1'b0);
    run(1, 1'b1);
    // short pulse swallowed
    dt_rise = 8'd8;
    dt_fall = 8'd2;
    run(15, 1'b0);
    run(4, 1'b1);
    run(15, 1'b0);
    // enable drop mid DEAD_R and mid HI_ON
    dt_rise = 8'd3;
    dt_fall = 8'd5;
    run(3, 1'b1);
    dt_en = 1'b0;
    run(2, 1'b1);
    dt_en = 1'b1;
    run(12, 1'b1);
    dt_en = 1'b0;
    run(2, 1'b1);
    run(2, 1'b0);
    dt_en = 1'b1;
    run(5, 1'b0);
    // reset during HI_ON
    run(15, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(10, 1'b1);
    // dead time changed mid interval
    dt_rise = 8'd10;
    run(10, 1'b0);
    run(3, 1'b1);
    dt_rise = 8'd2;
    run(15, 1'b1);
    // max dead time
    dt_rise = 8'd255;
    run(10, 1'b0);
    run(270, 1'b1);
    run(10, 1'b0);
`ifdef DT_FAULT_EN
    dt_rise = 8'd2;
    dt_fall = 8'd2;
    run(15, 1'b1);
    fault = 1'b1;
    step();
    fault = 1'b0;
    run(6, 1'b1);
    fault   = 1'b1;
    flt_clr = 1'b1;
    run(3, 1'b0);
    flt_clr = 1'b0;
    run(2, 1'b0);
    fault = 1'b0;
    run(4, 1'b0);
    flt_clr = 1'b1;
    step();
    flt_clr = 1'b0;
    run(10, 1'b0);
`endif
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 40) == 0) begin
        dt_rise = W'($urandom_range(0, 12));
        dt_fall = W'($urandom_range(0, 12));
      end
      dt_en = ($urandom_range(0, 99) != 0);
      rst   = ($urandom_range(0, 299) == 0);
`ifdef DT_FAULT_EN
      fault   = ($urandom_range(0, 199) == 0);
      flt_clr = ($urandom_range(0, 19) == 0);
`endif
      step();
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
